// File: rtl/seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seg_display_arbiter
// Description : Shares one eight-digit seven-segment display among four
//               requesters. Ownership is granted round-robin, and an owner
//               keeps the display for at least DWELL cycles before a waiting
//               requester can preempt it. All outputs are registered and feed
//               the seg0..seg7 inputs of the scan/decoder block.
// Ports       :
//   clk     in   1    system clock, all state updates on posedge
//   rst_n   in   1    synchronous reset, active low
//   req     in   4    level request per requester, held while wanted
//   data    in   128  data[32i+31:32i] = 8 BCD digits of requester i
//   grant   out  4    one-hot owner, all-zero when idle
//   owner   out  2    index of current owner (last owner when idle)
//   busy    out  1    high while an owner holds the display
//   digits  out  32   digits[4k+3:4k] -> seg k, all-ones = blank
// Revision    : 1.0  initial release
// ============================================================================
module seg_display_arbiter #(
  parameter int DWELL = 100_000_000,
  parameter int CW    = 27
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [127:0] data,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic         busy,
  output logic [31:0]  digits
);

  localparam logic [31:0]   BLANK     = 32'hFFFF_FFFF;
  localparam logic [CW-1:0] DWELL_MAX = CW'(DWELL - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_n;
  logic [3:0]    grant_q, grant_n;
  logic [1:0]    owner_q, owner_n;
  logic          busy_q,  busy_n;
  logic [31:0]   digits_q, digits_n;
  logic [CW-1:0] cnt_q,   cnt_n;
  logic [1:0]    rr_q,    rr_n;

  logic [31:0]   lane [4];
  logic [3:0]    cand;
  logic          found;
  logic [1:0]    win;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane[i] = data[32*i +: 32];
    end
  end

  // Candidates exclude the current owner while holding, so a handover or
  // preemption always moves the display to a different requester.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = rr_q;
    cand  = (state_q == HOLD) ? (req & ~(4'b0001 << owner_q)) : req;
    for (int i = 0; i < 4; i++) begin
      idx = rr_q + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    grant_n  = grant_q;
    owner_n  = owner_q;
    busy_n   = busy_q;
    digits_n = digits_q;
    cnt_n    = cnt_q;
    rr_n     = rr_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_n  = HOLD;
          grant_n  = 4'b0001 << win;
          owner_n  = win;
          busy_n   = 1'b1;
          digits_n = lane[win];
          cnt_n    = DWELL_MAX;
          rr_n     = win + 2'd1;
        end
      end
      HOLD: begin
        // A released owner hands over at once; a still-requesting owner is
        // only displaced once its dwell has expired and someone is waiting.
        if ((!req[owner_q] || cnt_q == '0) && found) begin
          grant_n  = 4'b0001 << win;
          owner_n  = win;
          digits_n = lane[win];
          cnt_n    = DWELL_MAX;
          rr_n     = win + 2'd1;
        end else if (!req[owner_q]) begin
          state_n  = IDLE;
          grant_n  = 4'b0000;
          busy_n   = 1'b0;
          digits_n = BLANK;
        end else begin
          digits_n = lane[owner_q];
          if (cnt_q != '0) begin
            cnt_n = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 4'b0000;
      owner_q  <= 2'd0;
      busy_q   <= 1'b0;
      digits_q <= BLANK;
      cnt_q    <= '0;
      rr_q     <= 2'd0;
    end else begin
      state_q  <= state_n;
      grant_q  <= grant_n;
      owner_q  <= owner_n;
      busy_q   <= busy_n;
      digits_q <= digits_n;
      cnt_q    <= cnt_n;
      rr_q     <= rr_n;
    end
  end

  assign grant  = grant_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign digits = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_display_arbiter
// Description : Self-checking bench for seg_display_arbiter (DWELL=4).
//               A behavioural model tracks who should own the display and
//               is compared with the DUT every cycle; directed scenarios
//               pin the model with literal expectations, then random
//               request/data/reset traffic runs against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg_display_arbiter;

  localparam int DWELL = 4;
  localparam int CW    = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         busy;
  logic [31:0]  digits;

  int checks   = 0;
  int failures = 0;

  seg_display_arbiter #(.DWELL(DWELL), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .data   (data),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .digits (digits)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Model state: who owns the display (or nobody), how many edges the owner
  // has stayed, and where the round-robin search starts next.
  bit          m_valid = 0;
  bit          m_busy;
  int          m_owner;
  int          m_rr;
  int          m_age;
  logic [31:0] m_digits;
  int          m_win;
  bit          m_found;

  task automatic m_take(input int w);
    m_busy   = 1;
    m_owner  = w;
    m_digits = data[32*w +: 32];
    m_age    = 0;
    m_rr     = (w + 1) % 4;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1;
      m_busy   = 0;
      m_owner  = 0;
      m_rr     = 0;
      m_age    = 0;
      m_digits = 32'hFFFF_FFFF;
    end else if (m_valid) begin
      m_found = 0;
      m_win   = 0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (!m_found && req[c] && !(m_busy && c == m_owner)) begin
          m_found = 1;
          m_win   = c;
        end
      end
      if (!m_busy) begin
        if (m_found) m_take(m_win);
      end else if (!req[m_owner]) begin
        if (m_found) m_take(m_win);
        else begin
          m_busy   = 0;
          m_digits = 32'hFFFF_FFFF;
        end
      end else if (m_found && m_age >= DWELL - 1) begin
        m_take(m_win);
      end else begin
        if (m_age < DWELL) m_age = m_age + 1;
        m_digits = data[32*m_owner +: 32];
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      logic [3:0] eg;
      eg = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (grant !== eg || owner !== 2'(m_owner) || busy !== m_busy || digits !== m_digits) begin
        failures++;
        $display("FAIL model t=%0t grant=%b/%b owner=%0d/%0d busy=%b/%b digits=%h/%h (actual/required)",
                 $time, grant, eg, owner, m_owner, busy, m_busy, digits, m_digits);
      end
      checks++;
      if (busy !== (|grant) || (grant & (grant - 4'd1)) !== 4'b0000) begin
        failures++;
        $display("FAIL onehot t=%0t grant=%b busy=%b (required one-hot/zero, busy==|grant)",
                 $time, grant, busy);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    data  = {32'hDDDD_4444, 32'hCCCC_3333, 32'hBBBB_2222, 32'hAAAA_1111};

    // 1: reset held with all requests
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_digits", 64'(digits), 64'hFFFF_FFFF);
    end

    // 2: single requester 2, live data tracking, held past dwell
    rst_n = 1'b1;
    req   = 4'b0100;
    data[95:64] = 32'h1234_5678;
    step(1);
    chk("t2_grant", 64'(grant), 64'h4);
    chk("t2_owner", 64'(owner), 64'h2);
    chk("t2_digits", 64'(digits), 64'h1234_5678);
    data[95:64] = 32'h8765_4321;
    step(1);
    chk("t2_track", 64'(digits), 64'h8765_4321);
    step(20);
    chk("t2_hold", 64'({grant, busy}), 64'h9);

    // 3: all requesting from reset, 4 cycles each, gapless
    do_reset(4'b1111);
    for (int i = 0; i < 17; i++) begin
      step(1);
      chk("t3_seq", 64'(grant), 64'(4'b0001 << ((i / 4) % 4)));
    end

    // 4: owner 1 releases after 2 cycles while 3 waits
    do_reset(4'b0010);
    step(1);
    chk("t4_own1", 64'(grant), 64'h2);
    req = 4'b1010;
    step(1);
    req = 4'b1000;
    step(1);
    chk("t4_hand", 64'(grant), 64'h8);
    chk("t4_digits", 64'(digits), 64'hDDDD_4444);
    req = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t4_dwell", 64'(grant), 64'h8);
    end
    step(1);
    chk("t4_preempt", 64'(grant), 64'h2);

    // 5: sole owner 0 releases, then rr pointer favours 1
    do_reset(4'b0001);
    step(1);
    chk("t5_own0", 64'(grant), 64'h1);
    req = 4'b0000;
    step(1);
    chk("t5_idle", 64'({grant, owner, busy}), 64'h0);
    chk("t5_blank", 64'(digits), 64'hFFFF_FFFF);
    req = 4'b0011;
    step(1);
    chk("t5_rr", 64'(grant), 64'h2);

    // 6: reset mid-hold of owner 2
    do_reset(4'b0100);
    step(2);
    chk("t6_own2", 64'(grant), 64'h4);
    rst_n = 1'b0;
    step(1);
    chk("t6_rst", 64'({grant, owner, busy}), 64'h0);
    chk("t6_blank", 64'(digits), 64'hFFFF_FFFF);
    rst_n = 1'b1;
    req   = 4'b1111;
    step(1);
    chk("t6_first", 64'(grant), 64'h1);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 3) == 0) begin
        data[32*$urandom_range(0, 3) +: 32] = $urandom;
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
